// File: rtl/alu_operand_seq_if.sv
// Operand/result bus between the operand sequencer and its driver/consumer.
// The overrun signal exists only when ALU_OVERRUN_EN is defined.
interface alu_operand_seq_if #(
  parameter int unsigned N = 4
);
  logic         load;
  logic [N-1:0] din;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] S_in;
  logic [N-1:0] result;
  logic         zero;
  logic         valid;
  logic         ack;
  logic         ready;
`ifdef ALU_OVERRUN_EN
  logic         overrun;
`endif

  modport master (
    output load, din, S_in, ack,
    input  A, B, result, zero, valid, ready
`ifdef ALU_OVERRUN_EN
    , input overrun
`endif
  );

  modport slave (
    input  load, din, S_in, ack,
    output A, B, result, zero, valid, ready
`ifdef ALU_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/alu_operand_seq.sv
// Operand sequencer: loads A then B from a shared bus, waits EXEC_CYCLES, captures S_in.
// Optional sticky overrun flag when ALU_OVERRUN_EN is defined.
module alu_operand_seq #(
  parameter int unsigned N           = 4,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  alu_operand_seq_if.slave bus
);

  localparam int unsigned CntW = (EXEC_CYCLES < 2) ? 1 : $clog2(EXEC_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StGotA, StExec, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    result_q;
  logic            zero_q;
  logic [CntW-1:0] cnt_q;
`ifdef ALU_OVERRUN_EN
  logic            overrun_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef ALU_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.load) begin
            a_q     <= bus.din;
            state_q <= StGotA;
          end
        end
        StGotA: begin
          if (bus.load) begin
            b_q     <= bus.din;
            cnt_q   <= CntW'(EXEC_CYCLES - 1);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            result_q <= bus.S_in;
            zero_q   <= (bus.S_in == '0);
            state_q  <= StDone;
          end
`ifdef ALU_OVERRUN_EN
          if (bus.load) overrun_q <= 1'b1;
`endif
        end
        StDone: begin
          // A load coinciding with ack starts the next operation immediately.
          if (bus.ack) begin
            if (bus.load) begin
              a_q     <= bus.din;
              state_q <= StGotA;
            end else begin
              state_q <= StIdle;
            end
          end
`ifdef ALU_OVERRUN_EN
          else if (bus.load) begin
            overrun_q <= 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.valid  = (state_q == StDone);
  assign bus.ready  = (state_q == StIdle) || (state_q == StGotA);
`ifdef ALU_OVERRUN_EN
  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed + randomized bench for alu_operand_seq with an AND unit attached.
// Runs a 1-cycle and a 3-cycle instance; overrun checks compile in with ALU_OVERRUN_EN.
module tb_alu_operand_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_operand_seq_if #(.N(4)) b1 ();
  alu_operand_seq_if #(.N(4)) b3 ();

  // The attached logic unit is a plain N-bit AND.
  assign b1.S_in = b1.A & b1.B;
  assign b3.S_in = b3.A & b3.B;

  alu_operand_seq #(.N(4), .EXEC_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  alu_operand_seq #(.N(4), .EXEC_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [3:0] a, input logic [3:0] b);
    b1.load = 1'b1;
    b1.din  = a;
    step();
    b1.din  = b;
    step();
    b1.load = 1'b0;
    b1.din  = 4'($urandom_range(15, 0));
  endtask

  // Cycles after the B-load edge until valid; saturates at the bound.
  task automatic wait_valid(output int n);
    n = 0;
    while (!b1.valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic do_ack();
    b1.ack = 1'b1;
    step();
    b1.ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] a;
    logic [3:0] b;
    b1.load = 1'b0; b1.din = '0; b1.ack = 1'b0;
    b3.load = 1'b0; b3.din = '0; b3.ack = 1'b0;
    step();
    step();
    chk("rst_A", 32'(b1.A), 0);
    chk("rst_B", 32'(b1.B), 0);
    chk("rst_result", 32'(b1.result), 0);
    chk("rst_zero", 32'(b1.zero), 0);
    chk("rst_valid", 32'(b1.valid), 0);
    chk("rst_ready", 32'(b1.ready), 1);
    rst = 1'b0;
    step();

    // 1111 & 0110, two-cycle latency from the B load.
    load_pair(4'hf, 4'h6);
    chk("t2_A", 32'(b1.A), 32'h f);
    chk("t2_B", 32'(b1.B), 32'h6);
    chk("t2_ready_exec", 32'(b1.ready), 0);
    wait_valid(n);
    chk("t2_latency", 32'(n), 1);
    chk("t2_result", 32'(b1.result), 32'h6);
    chk("t2_zero", 32'(b1.zero), 0);
    do_ack();
    chk("t2_valid_drop", 32'(b1.valid), 0);
    chk("t2_ready_idle", 32'(b1.ready), 1);

    // Zero result, held for 5 cycles without ack.
    load_pair(4'h0, 4'hf);
    wait_valid(n);
    chk("t3_result", 32'(b1.result), 0);
    chk("t3_zero", 32'(b1.zero), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(b1.valid), 1);
      chk("t3_hold_result", 32'(b1.result), 0);
    end
    do_ack();

    // ack + load together in DONE: back-to-back start.
    load_pair(4'ha, 4'hf);
    wait_valid(n);
    chk("t4_result", 32'(b1.result), 32'ha);
    b1.ack = 1'b1; b1.load = 1'b1; b1.din = 4'h3;
    step();
    b1.ack = 1'b0; b1.load = 1'b0;
    chk("t4_valid", 32'(b1.valid), 0);
    chk("t4_ready", 32'(b1.ready), 1);
    chk("t4_A", 32'(b1.A), 32'h3);
    // ack in GOT_A must be ignored.
    b1.ack = 1'b1;
    step();
    b1.ack = 1'b0;
    chk("t4_ack_ignored_ready", 32'(b1.ready), 1);
    chk("t4_ack_ignored_A", 32'(b1.A), 32'h3);
    b1.load = 1'b1; b1.din = 4'h5;
    step();
    b1.load = 1'b0;
    wait_valid(n);
    chk("t4_second_result", 32'(b1.result), 32'h1);
    do_ack();

    // Asynchronous reset mid-EXEC.
    load_pair(4'hf, 4'h6);
    #1 rst = 1'b1;
    #1;
    chk("t1_A", 32'(b1.A), 0);
    chk("t1_B", 32'(b1.B), 0);
    chk("t1_result", 32'(b1.result), 0);
    chk("t1_valid", 32'(b1.valid), 0);
    chk("t1_ready", 32'(b1.ready), 1);
    #1 rst = 1'b0;
    step();

    // Randomized operations checked against a & b.
    for (int k = 0; k < 12; k++) begin
      a = 4'($urandom_range(15, 0));
      b = 4'($urandom_range(15, 0));
      load_pair(a, b);
      wait_valid(n);
      chk("rnd_latency", 32'(n), 1);
      chk("rnd_result", 32'(b1.result), 32'(a & b));
      chk("rnd_zero", 32'(b1.zero), 32'((a & b) == 4'h0));
      for (int d = $urandom_range(3, 0); d > 0; d--) step();
      chk("rnd_held", 32'(b1.result), 32'(a & b));
      do_ack();
      chk("rnd_valid_drop", 32'(b1.valid), 0);
    end

    // Load while valid and unacknowledged is dropped.
`ifdef ALU_OVERRUN_EN
    chk("ov_clear_initial", 32'(b1.overrun), 0);
`endif
    load_pair(4'h9, 4'h3);
    wait_valid(n);
    b1.load = 1'b1; b1.din = 4'h6;
    step();
    b1.load = 1'b0;
    chk("ov_A_kept", 32'(b1.A), 32'h9);
    chk("ov_B_kept", 32'(b1.B), 32'h3);
    chk("ov_valid", 32'(b1.valid), 1);
    chk("ov_result", 32'(b1.result), 32'h1);
`ifdef ALU_OVERRUN_EN
    chk("ov_set", 32'(b1.overrun), 1);
`endif
    do_ack();
    load_pair(4'hc, 4'h4);
    wait_valid(n);
    chk("ov_next_result", 32'(b1.result), 32'h4);
`ifdef ALU_OVERRUN_EN
    chk("ov_sticky", 32'(b1.overrun), 1);
`endif
    do_ack();

    // EXEC_CYCLES=3 instance: 4-cycle latency, load during EXEC ignored.
    b3.load = 1'b1; b3.din = 4'ha;
    step();
    b3.din = 4'hf;
    step();
    b3.din = 4'h0;
    step();
    b3.load = 1'b0;
    n = 1;
    while (!b3.valid && n < 20) begin
      step();
      n++;
    end
    chk("t5_latency", 32'(n), 3);
    chk("t5_B", 32'(b3.B), 32'hf);
    chk("t5_result", 32'(b3.result), 32'ha);
`ifdef ALU_OVERRUN_EN
    chk("t5_overrun", 32'(b3.overrun), 1);
`endif

    #2 rst = 1'b1;
    #1;
`ifdef ALU_OVERRUN_EN
    chk("ov_cleared_by_rst", 32'(b1.overrun), 0);
`endif
    chk("end_rst_valid3", 32'(b3.valid), 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
